cache_replacement: RTL and testbench

- Parametrised replacement-policy unit that succeeds the tree pseudo-LRU and sits beside the tag/valid arrays in the I$ and D$.
- Per-set replacement state is held in an internal 2-port array with read-during-write bypass.
- Policy is runtime-selectable: tree PLRU, per-set round-robin, or global LFSR pseudo-random.
- Adds a multi-cycle state-clear sequencer.

---
 rtl/cache_repl_pkg.sv | 21 ++
 rtl/cache_replacement_plru_tree.sv | 33 +++
 rtl/cache_replacement.sv | 128 ++++++++++++
 tb/tb_cache_replacement.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_repl_pkg.sv
// cache_repl_pkg: shared policy encoding, LFSR constants and clear-sequencer state type
package cache_repl_pkg;

    typedef enum logic [1:0] {
        REPL_PLRU = 2'b00,
        REPL_RR   = 2'b01,
        REPL_RAND = 2'b10
    } repl_policy_t;

    localparam int LFSRWIDTH = 16;
    localparam logic [LFSRWIDTH-1:0] LFSRTAPS = 16'hB400;

    typedef logic [0:0] clrState_t;
    localparam clrState_t CLR_IDLE = 1'b0;
    localparam clrState_t CLR_BUSY = 1'b1;

    function automatic logic [LFSRWIDTH-1:0] lfsrNext(input logic [LFSRWIDTH-1:0] cur);
        return {cur[LFSRWIDTH-2:0], ^(cur & LFSRTAPS)};
    endfunction

endpackage

// File: rtl/cache_replacement_plru_tree.sv
// plru_tree: next-state and victim encoding for a heap-ordered (NUMWAYS-1)-bit PLRU tree
module plru_tree #(
    parameter int NUMWAYS = 4,
    localparam int LOGNUMWAYS = $clog2(NUMWAYS)
) (
    input  logic [NUMWAYS-2:0]    state,
    input  logic [LOGNUMWAYS-1:0] updIdx,
    output logic [NUMWAYS-2:0]    nextState,
    output logic [LOGNUMWAYS-1:0] victimIdx
);

    logic [LOGNUMWAYS-1:0] upNode, vicNode;

    // Node n has children 2n+1 / 2n+2; a set bit points the victim walk to the right child.
    always_comb begin
        nextState = state;
        upNode = '0;
        for (int l = 0; l < LOGNUMWAYS; l++) begin
            nextState[upNode] = ~updIdx[LOGNUMWAYS-1-l];
            upNode = LOGNUMWAYS'(2 * int'(upNode) + 1 + int'(updIdx[LOGNUMWAYS-1-l]));
        end
    end

    always_comb begin
        victimIdx = '0;
        vicNode = '0;
        for (int l = 0; l < LOGNUMWAYS; l++) begin
            victimIdx[LOGNUMWAYS-1-l] = state[vicNode];
            vicNode = LOGNUMWAYS'(2 * int'(vicNode) + 1 + int'(state[vicNode]));
        end
    end

endmodule

// File: rtl/cache_replacement.sv
// cache_replacement: per-set PLRU / round-robin / LFSR-random victim selection with a state-clear sequencer
// Define REPLACE_WAYLOCK_EN to add the LockMask port and NoVictim reporting.
module cache_replacement
    import cache_repl_pkg::*;
#(
    parameter int NUMWAYS = 4,
    parameter int SETLEN = 9,
    parameter int NUMLINES = 128,
    parameter logic [LFSRWIDTH-1:0] LFSRSEED = 16'h0001
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               CacheEn,
    input  logic [1:0]         Policy,
    input  logic [NUMWAYS-1:0] HitWay,
    input  logic [NUMWAYS-1:0] ValidWay,
    input  logic [SETLEN-1:0]  CacheSet,
    input  logic [SETLEN-1:0]  PAdr,
    input  logic               LRUWriteEn,
    input  logic               SetValid,
    input  logic               ClearStart,
`ifdef REPLACE_WAYLOCK_EN
    input  logic [NUMWAYS-1:0] LockMask,
`endif
    output logic               ClearBusy,
    output logic [NUMWAYS-1:0] VictimWay,
    output logic               NoVictim
);

    localparam int LOGNUMWAYS = $clog2(NUMWAYS);
    localparam int SETW = $clog2(NUMLINES);
    localparam int STW = NUMWAYS - 1;

    logic [STW-1:0] lruMem [NUMLINES];
    logic [STW-1:0] CurrState, rdState, newState, plruNext;
    logic [LFSRWIDTH-1:0] lfsr;
    logic [LOGNUMWAYS-1:0] plruVictim, choice, updIdx, probe;
    logic [NUMWAYS-1:0] lockMask, cand;
    clrState_t clrState;
    logic [SETW-1:0] clrIdx;
    logic isRR, isRand, isPlru, fillEn, wrArr, rdInRange, wrInRange;

    function automatic logic [LOGNUMWAYS-1:0] oh2idx(input logic [NUMWAYS-1:0] oh);
        oh2idx = '0;
        for (int i = 0; i < NUMWAYS; i++)
            if (oh[i]) oh2idx = oh2idx | LOGNUMWAYS'(i);
    endfunction

`ifdef REPLACE_WAYLOCK_EN
    assign lockMask = LockMask;
    assign NoVictim = &LockMask;
`else
    assign lockMask = '0;
    assign NoVictim = 1'b0;
`endif

    assign isRR = Policy == REPL_RR;
    assign isRand = Policy == REPL_RAND;
    assign isPlru = ~isRR & ~isRand;
    assign ClearBusy = clrState == CLR_BUSY;
    assign rdInRange = int'(CacheSet) < NUMLINES;
    assign wrInRange = int'(PAdr) < NUMLINES;
    assign rdState = rdInRange ? lruMem[CacheSet[SETW-1:0]] : '0;
    assign choice = isRR ? CurrState[LOGNUMWAYS-1:0] : isRand ? lfsr[LOGNUMWAYS-1:0] : plruVictim;

    // Invalid unlocked ways win; otherwise walk upward from the policy choice to the first unlocked way.
    always_comb begin
        cand = ~ValidWay & ~lockMask;
        probe = choice;
        VictimWay = '0;
        if (|cand) VictimWay = cand & -cand;
        else
            for (int k = NUMWAYS - 1; k >= 0; k--) begin
                probe = choice + LOGNUMWAYS'(k);
                if (!lockMask[probe]) VictimWay = NUMWAYS'(1) << probe;
            end
    end

    plru_tree #(.NUMWAYS(NUMWAYS)) plruTree (
        .state(CurrState),
        .updIdx(updIdx),
        .nextState(plruNext),
        .victimIdx(plruVictim)
    );

    assign updIdx = oh2idx(SetValid ? VictimWay : HitWay);
    assign fillEn = CacheEn & LRUWriteEn & SetValid & ~ClearBusy & ~NoVictim;
    assign wrArr = CacheEn & LRUWriteEn & ~ClearBusy & (SetValid ? ~NoVictim & ~isRand : isPlru);

    always_comb begin
        newState = plruNext;
        if (isRR) begin
            newState = CurrState;
            newState[LOGNUMWAYS-1:0] = updIdx + LOGNUMWAYS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clrState <= CLR_IDLE;
            clrIdx <= '0;
        end else if (ClearBusy) begin
            clrState <= clrIdx == SETW'(NUMLINES - 1) ? CLR_IDLE : CLR_BUSY;
            clrIdx <= clrIdx + SETW'(1);
        end else if (ClearStart) begin
            clrState <= CLR_BUSY;
            clrIdx <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) for (int i = 0; i < NUMLINES; i++) lruMem[i] <= '0;
        else if (ClearBusy) lruMem[clrIdx] <= '0;
        else if (wrArr && wrInRange) lruMem[PAdr[SETW-1:0]] <= newState;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            CurrState <= '0;
            lfsr <= LFSRSEED;
        end else begin
            if (ClearBusy) CurrState <= '0;
            else if (CacheEn) CurrState <= wrArr && PAdr == CacheSet ? newState : rdState;
            if (fillEn) lfsr <= lfsrNext(lfsr);
        end
    end

endmodule

// File: tb/tb_cache_replacement.sv
// tb_cache_replacement: directed and randomized checks of cache_replacement against a behavioural model
module tb_cache_replacement;

    logic clk = 0, reset = 1, CacheEn = 1, LRUWriteEn = 0, SetValid = 0, ClearStart = 0;
    logic [1:0] Policy = 0;
    logic [3:0] HitWay = 0, ValidWay = 4'hF;
    logic [8:0] CacheSet = 0, PAdr = 0;
    logic ClearBusy, NoVictim;
    logic [3:0] VictimWay;
`ifdef REPLACE_WAYLOCK_EN
    logic [3:0] LockMask = 0;
`endif

    int tests = 0, failures = 0;
    int pol = 0;
    int tree [128][3];
    int rrc [128];
    int lfsr = 1;

    always #5 clk = ~clk;

    cache_replacement dut (
        .clk(clk),
        .reset(reset),
        .CacheEn(CacheEn),
        .Policy(Policy),
        .HitWay(HitWay),
        .ValidWay(ValidWay),
        .CacheSet(CacheSet),
        .PAdr(PAdr),
        .LRUWriteEn(LRUWriteEn),
        .SetValid(SetValid),
        .ClearStart(ClearStart),
`ifdef REPLACE_WAYLOCK_EN
        .LockMask(LockMask),
`endif
        .ClearBusy(ClearBusy),
        .VictimWay(VictimWay),
        .NoVictim(NoVictim)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int w);
        return 4'(1 << w);
    endfunction

    function automatic void mdlClear();
        for (int s = 0; s < 128; s++) begin
            rrc[s] = 0;
            for (int n = 0; n < 3; n++) tree[s][n] = 0;
        end
    endfunction

    // Victim per the policy rules: lowest invalid way, else RR counter, LFSR low bits, or the PLRU walk.
    function automatic int mdlVictim(input int s, input logic [3:0] vld);
        int hi;
        for (int i = 0; i < 4; i++) if (!vld[i]) return i;
        if (pol == 1) return rrc[s];
        if (pol == 2) return lfsr % 4;
        hi = tree[s][0];
        return 2 * hi + tree[s][1 + hi];
    endfunction

    function automatic void mdlWrite(input int s, input bit fill, input int hitw, input logic [3:0] vld);
        int w;
        w = fill ? mdlVictim(s, vld) : hitw;
        if (pol == 1) begin
            if (fill) rrc[s] = (w + 1) % 4;
        end else if (pol != 2) begin
            tree[s][0] = 1 - w / 2;
            tree[s][1 + w / 2] = 1 - w % 2;
        end
        if (fill) lfsr = ((lfsr << 1) | (((lfsr >> 15) ^ (lfsr >> 13) ^ (lfsr >> 12) ^ (lfsr >> 10)) & 1)) & 16'hFFFF;
    endfunction

    task automatic look(input int s, input logic [3:0] vld);
        ValidWay = vld;
        CacheSet = 9'(s);
        PAdr = 9'(s);
        LRUWriteEn = 0;
        SetValid = 0;
        tick();
    endtask

    task automatic op(input int s, input bit fill, input int hitw, input logic [3:0] vld, input string tag);
        look(s, vld);
        check(tag, VictimWay, oh(mdlVictim(s, vld)));
        LRUWriteEn = 1;
        SetValid = fill;
        HitWay = oh(hitw);
        tick();
        mdlWrite(s, fill, hitw, vld);
        LRUWriteEn = 0;
        SetValid = 0;
    endtask

    function automatic logic [3:0] rndValid();
        return ($urandom % 4 == 0) ? 4'($urandom) : 4'hF;
    endfunction

    initial begin
        int n, s;
        logic [3:0] exp;
        mdlClear();
        repeat (2) tick();
        check("rst_busy", ClearBusy, 0);
        check("rst_novictim", NoVictim, 0);
        check("rst_victim", VictimWay, 4'b0001);
        ValidWay = 4'b0111;
        #1 check("rst_invalid3", VictimWay, 4'b1000);
        reset = 0;
        ValidWay = 4'hF;

        for (int w = 0; w < 4; w++) op(5, 0, w, 4'hF, "plru_seq");
        look(5, 4'hF);
        check("plru_after_hits", VictimWay, 4'b0001);
        op(5, 0, 0, 4'hF, "plru_seq");
        look(5, 4'hF);
        check("plru_after_hit0", VictimWay, 4'b0100);

        for (int i = 0; i < 80; i++) op(8 + $urandom % 8, 1'($urandom % 2), $urandom % 4, rndValid(), "plru_rand");
        Policy = 3;
        pol = 3;
        for (int i = 0; i < 20; i++) op(8 + $urandom % 8, 1'($urandom % 2), $urandom % 4, rndValid(), "pol3_rand");
        Policy = 0;
        pol = 0;

        look(5, 4'hF);
        exp = oh(mdlVictim(5, 4'hF));
        CacheEn = 0;
        CacheSet = 9'd9;
        tick();
        check("cacheen_hold", VictimWay, exp);
        CacheEn = 1;

        for (int p = 0; p < 4; p++) begin
            Policy = 2'(p);
            look(12, 4'b1011);
            check("invalid_prio", VictimWay, 4'b0100);
        end
        Policy = 0;

        look(7, 4'hF);
        check("bypass_before", VictimWay, 4'b0001);
        LRUWriteEn = 1;
        HitWay = 4'b0001;
        tick();
        mdlWrite(7, 0, 0, 4'hF);
        check("bypass_after", VictimWay, 4'b0100);
        LRUWriteEn = 0;

        ClearStart = 1;
        tick();
        CacheSet = 3;
        PAdr = 3;
        LRUWriteEn = 1;
        SetValid = 1;
        n = 0;
        while (ClearBusy && n < 300) begin
            n++;
            ClearStart = n == 64;
            tick();
        end
        check("clear_cycles", 16'(n), 128);
        ClearStart = 0;
        LRUWriteEn = 0;
        SetValid = 0;
        mdlClear();
        for (int i = 0; i < 6; i++) begin
            s = (i < 3) ? 5 + i : $urandom % 128;
            look(s, 4'hF);
            check("clear_zero_plru", VictimWay, 4'b0001);
        end

        Policy = 1;
        pol = 1;
        for (int i = 0; i < 5; i++) begin
            look(3, 4'hF);
            check("rr_fill", VictimWay, oh(i % 4));
            op(3, 1, 0, 4'hF, "rr_fill_model");
            op(3, 0, $urandom % 4, 4'hF, "rr_hit");
        end
        for (int i = 0; i < 60; i++) op(16 + $urandom % 8, 1'($urandom % 2), $urandom % 4, rndValid(), "rr_rand");
        op(100, 1, 0, 4'hF, "rr_set100");

        ClearStart = 1;
        tick();
        ClearStart = 0;
        repeat (39) tick();
        check("midclear_busy", ClearBusy, 1);
        reset = 1;
        tick();
        check("midclear_reset", ClearBusy, 0);
        reset = 0;
        mdlClear();
        lfsr = 1;
        look(100, 4'hF);
        check("reset_array", VictimWay, 4'b0001);

        Policy = 2;
        pol = 2;
        for (int i = 0; i < 20; i++) begin
            s = $urandom % 128;
            look(s, 4'hF);
            check("rand_fill", VictimWay, oh(lfsr % 4));
            op(s, 1, 0, 4'hF, "rand_fill_model");
            op(s, 0, $urandom % 4, 4'hF, "rand_hit");
        end

`ifdef REPLACE_WAYLOCK_EN
        Policy = 0;
        pol = 0;
        look(50, 4'hF);
        LockMask = 4'b0101;
        #1 check("lock_skip", VictimWay, 4'b0010);
        check("lock_some_nov", NoVictim, 0);
        LockMask = 4'b1111;
        #1 check("lock_all_nov", NoVictim, 1);
        check("lock_all_victim", VictimWay, 4'b0000);
        LockMask = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
